// File: rtl/stateram_sequencer.sv
// stateram_sequencer: address/strobe generator for the 25 per-lane Keccak
// state RAMs. Sweeps every sub-round of every round in read-modify-write
// order (write-back one cycle behind each read) and reports round/sub-round
// indices to the round datapath. All outputs are registered.
//
// Optional feature: define STATERAM_SEQ_EXT_ACCESS_EN to add ext_re/ext_we/
// ext_addr, which pass through to the RAM bus while idle (absorb/squeeze).
//
// state_q names the bus cycle that will be issued at the next un-stalled
// edge; the output flops hold the cycle currently on the bus.
module stateram_sequencer #(
  parameter int MAX_SUB_ROUNDS = 7,
  parameter int NUM_ROUNDS     = 24,
  parameter int HIGH_OFFSET    = 1
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                start,
  input  logic                                stall,
`ifdef STATERAM_SEQ_EXT_ACCESS_EN
  input  logic                                ext_re,
  input  logic                                ext_we,
  input  logic [31:0]                         ext_addr,
`endif
  output logic                                re,
  output logic                                we,
  output logic [31:0]                         raddr,
  output logic [31:0]                         raddr_high_offset,
  output logic [4:0]                          round_idx,
  output logic [$clog2(MAX_SUB_ROUNDS+1)-1:0] sub_idx,
  output logic                                first_sub,
  output logic                                last_sub,
  output logic                                busy,
  output logic                                done
);

  localparam int               SUB_W  = $clog2(MAX_SUB_ROUNDS + 1);
  localparam logic [SUB_W-1:0] S_LAST = SUB_W'(MAX_SUB_ROUNDS);
  localparam logic [4:0]       R_LAST = 5'(NUM_ROUNDS - 1);

  typedef enum logic [2:0] {
    IDLE,
    PRIME,
    SWEEP,
    DRAIN,
    DONE
  } state_e;

  state_e           state_q, state_d;
  logic [4:0]       r_q, r_d;
  logic [SUB_W-1:0] s_q, s_d;

  logic             re_q, re_d;
  logic             we_q, we_d;
  logic [31:0]      raddr_q, raddr_d;
  logic [31:0]      raddr_high_offset_q, raddr_high_offset_d;
  logic [4:0]       round_idx_q, round_idx_d;
  logic [SUB_W-1:0] sub_idx_q, sub_idx_d;
  logic             first_sub_q, first_sub_d;
  logic             last_sub_q, last_sub_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  // Sequencer registers: control state, counters and the registered bus.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q             <= IDLE;
      r_q                 <= '0;
      s_q                 <= '0;
      re_q                <= 1'b0;
      we_q                <= 1'b0;
      raddr_q             <= '0;
      raddr_high_offset_q <= '0;
      round_idx_q         <= '0;
      sub_idx_q           <= '0;
      first_sub_q         <= 1'b0;
      last_sub_q          <= 1'b0;
      busy_q              <= 1'b0;
      done_q              <= 1'b0;
    end else begin
      state_q             <= state_d;
      r_q                 <= r_d;
      s_q                 <= s_d;
      re_q                <= re_d;
      we_q                <= we_d;
      raddr_q             <= raddr_d;
      raddr_high_offset_q <= raddr_high_offset_d;
      round_idx_q         <= round_idx_d;
      sub_idx_q           <= sub_idx_d;
      first_sub_q         <= first_sub_d;
      last_sub_q          <= last_sub_d;
      busy_q              <= busy_d;
      done_q              <= done_d;
    end
  end

  // Issue the pending cycle (or a strobe-less bubble on stall) and advance.
  always_comb begin
    state_d     = state_q;
    r_d         = r_q;
    s_d         = s_q;
    re_d        = 1'b0;
    we_d        = 1'b0;
    raddr_d     = raddr_q;
    round_idx_d = round_idx_q;
    // The RAM output always carries the sub-round of the last sequencer read.
    sub_idx_d   = (re_q && busy_q) ? raddr_q[SUB_W-1:0] : sub_idx_q;
    first_sub_d = 1'b0;
    last_sub_d  = 1'b0;
    busy_d      = busy_q;
    done_d      = 1'b0;

    case (state_q)
      IDLE: begin
        busy_d      = 1'b0;
        raddr_d     = '0;
        round_idx_d = '0;
        // The cycle carrying the done pulse still sees IDLE here, so a start
        // coincident with done is dropped by gating on done_q.
        if (start && !done_q) begin
          re_d        = 1'b1;
          raddr_d     = 32'(S_LAST);
          busy_d      = 1'b1;
          r_d         = '0;
          s_d         = '0;
          state_d     = SWEEP;
        end
`ifdef STATERAM_SEQ_EXT_ACCESS_EN
        else if (!done_q) begin
          re_d    = ext_re;
          we_d    = ext_we;
          raddr_d = ext_addr;
        end
`endif
      end

      PRIME: begin
        if (!stall) begin
          re_d        = 1'b1;
          raddr_d     = 32'(S_LAST);
          round_idx_d = r_q;
          busy_d      = 1'b1;
          s_d         = '0;
          state_d     = SWEEP;
        end
      end

      SWEEP: begin
        if (!stall) begin
          re_d        = 1'b1;
          we_d        = (s_q != '0);
          raddr_d     = 32'(s_q);
          round_idx_d = r_q;
          first_sub_d = (s_q == '0);
          last_sub_d  = (s_q == S_LAST);
          busy_d      = 1'b1;
          if (s_q == S_LAST) begin
            s_d     = '0;
            state_d = DRAIN;
          end else begin
            s_d = s_q + 1'b1;
          end
        end
      end

      DRAIN: begin
        if (!stall) begin
          we_d        = 1'b1;
          round_idx_d = r_q;
          busy_d      = 1'b1;
          if (r_q < R_LAST) begin
            r_d     = r_q + 1'b1;
            state_d = PRIME;
          end else begin
            state_d = DONE;
          end
        end
      end

      DONE: begin
        done_d      = 1'b1;
        busy_d      = 1'b0;
        raddr_d     = '0;
        round_idx_d = '0;
        state_d     = IDLE;
      end

      default: state_d = IDLE;
    endcase

    raddr_high_offset_d = busy_d ? 32'(HIGH_OFFSET) : '0;
  end

  assign re                = re_q;
  assign we                = we_q;
  assign raddr             = raddr_q;
  assign raddr_high_offset = raddr_high_offset_q;
  assign round_idx         = round_idx_q;
  assign sub_idx           = sub_idx_q;
  assign first_sub         = first_sub_q;
  assign last_sub          = last_sub_q;
  assign busy              = busy_q;
  assign done              = done_q;

endmodule
